// File: rtl/mul8bit_seq.sv
// mul8bit_seq: sequential 8x8 unsigned shift-and-add multiplier.
// Each RUN step ANDs the multiplicand with one replicated multiplier bit
// and adds the shifted partial product into a 16-bit accumulator.
// Latency is fixed at 8 steps; start/busy/done handshake.
module mul8bit_seq (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [7:0]  inA,
   input  logic [7:0]  inB,
   output logic [15:0] out,
   output logic        busy,
   output logic        done
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t      r_state;
   logic [7:0]  r_regA;
   logic [7:0]  r_regB;
   logic [15:0] r_acc;
   logic [2:0]  r_count;
   logic [15:0] r_out;
   logic        r_busy;
   logic        r_done;

   logic [7:0]  w_partial;
   logic [15:0] w_shifted;
   logic [15:0] w_sum;

   // 8-bit AND stage: multiplicand gated by the current multiplier bit,
   // then aligned to its bit weight and added to the accumulator
   always_comb begin
      w_partial = r_regA & {8{r_regB[r_count]}};
      w_shifted = {8'h00, w_partial} << r_count;
      w_sum     = r_acc + w_shifted;
   end

   // Control FSM with datapath registers; busy/done are registered
   // alongside the state so they always match the state decode
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_regA  <= '0;
         r_regB  <= '0;
         r_acc   <= '0;
         r_count <= '0;
         r_out   <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               r_done <= 1'b0;
               if (start) begin
                  r_regA  <= inA;
                  r_regB  <= inB;
                  r_acc   <= '0;
                  r_count <= '0;
                  r_state <= S_RUN;
                  r_busy  <= 1'b1;
               end else begin
                  r_busy  <= 1'b0;
               end
            end
            S_RUN: begin
               r_acc <= w_sum;
               if (r_count == 3'd7) begin
                  // Publish the sum including this final step
                  r_out   <= w_sum;
                  r_count <= '0;
                  r_state <= S_DONE;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
               end else begin
                  r_count <= r_count + 3'd1;
               end
            end
            S_DONE: begin
               r_done <= 1'b0;
               if (start) begin
                  r_regA  <= inA;
                  r_regB  <= inB;
                  r_acc   <= '0;
                  r_count <= '0;
                  r_state <= S_RUN;
                  r_busy  <= 1'b1;
               end else begin
                  r_state <= S_IDLE;
                  r_busy  <= 1'b0;
               end
            end
            default: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
               r_done  <= 1'b0;
            end
         endcase
      end
   end

   assign out  = r_out;
   assign busy = r_busy;
   assign done = r_done;

endmodule

// File: tb/tb_mul8bit_seq.sv
// Testbench for mul8bit_seq: table-driven products plus handshake corner cases.
// Expected products are queued at stimulus time and checked when done pulses.
module tb_mul8bit_seq;

   logic        clk;
   logic        reset;
   logic        start;
   logic [7:0]  inA;
   logic [7:0]  inB;
   logic [15:0] out;
   logic        busy;
   logic        done;

   int unsigned n_cmp  = 0;
   int unsigned n_fail = 0;

   logic [15:0] sb_q[$];

   typedef struct {
      logic [7:0]  a;
      logic [7:0]  b;
      logic [15:0] p;
   } vec_t;

   vec_t vecs[9];

   mul8bit_seq dut (
      .clk   (clk),
      .reset (reset),
      .start (start),
      .inA   (inA),
      .inB   (inB),
      .out   (out),
      .busy  (busy),
      .done  (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%04h expected 0x%04h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Scoreboard: every done pulse must match the oldest queued product
   always @(posedge clk) begin
      #1;
      if (done === 1'b1) begin
         if (sb_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL unexpected_done: got done=1 expected no pending product at %0t", $time);
         end else begin
            check("product", out, sb_q.pop_front());
         end
      end
   end

   // Wait for done, returning number of edges taken (0 if the bound expired)
   task automatic wait_done(input int unsigned bound, output int unsigned edges);
      edges = 0;
      for (int unsigned k = 1; k <= bound; k++) begin
         tick();
         if (done === 1'b1) begin
            edges = k;
            break;
         end
         check("busy_in_run", {15'd0, busy}, 16'd1);
      end
      if (edges == 0) begin
         n_cmp++;
         n_fail++;
         $display("FAIL done_timeout: got no done within %0d edges expected done", bound);
      end
   endtask

   task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic [15:0] p);
      int unsigned lat;
      inA   = a;
      inB   = b;
      start = 1'b1;
      sb_q.push_back(p);
      tick();                      // E0
      start = 1'b0;
      inA   = ~a;                  // must be ignored after acceptance
      inB   = ~b;
      check("busy_after_accept", {15'd0, busy}, 16'd1);
      wait_done(20, lat);
      check("latency", 16'(lat), 16'd8);
      check("busy_at_done", {15'd0, busy}, 16'd0);
      tick();                      // E9
      check("done_drops", {15'd0, done}, 16'd0);
      check("busy_after_done", {15'd0, busy}, 16'd0);
      check("out_holds", out, p);
   endtask

   initial begin
      int unsigned lat;
      vecs[0] = '{a: 8'hFF, b: 8'hFF, p: 16'hFE01};
      vecs[1] = '{a: 8'h00, b: 8'h5A, p: 16'h0000};
      vecs[2] = '{a: 8'h01, b: 8'hB7, p: 16'h00B7};
      vecs[3] = '{a: 8'hB7, b: 8'h01, p: 16'h00B7};
      vecs[4] = '{a: 8'd13, b: 8'd11, p: 16'h008F};
      vecs[5] = '{a: 8'd200, b: 8'd3, p: 16'h0258};
      vecs[6] = '{a: 8'hAA, b: 8'h55, p: 16'h3872};
      vecs[7] = '{a: 8'h80, b: 8'hFF, p: 16'h7F80};
      vecs[8] = '{a: 8'h80, b: 8'h80, p: 16'h4000};

      reset = 1'b1;
      start = 1'b1;
      inA   = 8'hFF;
      inB   = 8'hFF;

      // Reset with start held: nothing may start
      for (int i = 0; i < 2; i++) begin
         tick();
         check("reset_out", out, 16'h0000);
         check("reset_busy", {15'd0, busy}, 16'd0);
         check("reset_done", {15'd0, done}, 16'd0);
      end
      reset = 1'b0;
      start = 1'b0;
      tick();
      check("idle_busy", {15'd0, busy}, 16'd0);
      check("idle_out", out, 16'h0000);

      // Table of products
      for (int i = 0; i < 9; i++) begin
         run_op(vecs[i].a, vecs[i].b, vecs[i].p);
      end

      // Busy protection: start during RUN is ignored
      inA = 8'd13; inB = 8'd11; start = 1'b1;
      sb_q.push_back(16'h008F);
      tick();                      // E0
      start = 1'b0;
      tick(); tick();              // E1, E2
      inA = 8'hFF; inB = 8'hFF; start = 1'b1;
      tick();                      // E3
      start = 1'b0;
      check("busy_prot_busy", {15'd0, busy}, 16'd1);
      wait_done(20, lat);
      check("busy_prot_latency", 16'(lat + 3), 16'd8);
      for (int i = 0; i < 12; i++) begin
         tick();
         check("busy_prot_no_done", {15'd0, done}, 16'd0);
      end

      // Back-to-back: restart during DONE
      inA = 8'd13; inB = 8'd11; start = 1'b1;
      sb_q.push_back(16'h008F);
      tick();
      start = 1'b0;
      wait_done(20, lat);
      check("b2b_first_latency", 16'(lat), 16'd8);
      inA = 8'd200; inB = 8'd3; start = 1'b1;
      sb_q.push_back(16'h0258);
      tick();                      // E9 accepts
      start = 1'b0;
      check("b2b_busy", {15'd0, busy}, 16'd1);
      check("b2b_out_hold", out, 16'h008F);
      wait_done(20, lat);
      check("b2b_spacing", 16'(lat + 1), 16'd9);
      tick();
      check("b2b_done_drop", {15'd0, done}, 16'd0);

      // Reset mid-operation aborts without done
      inA = 8'h80; inB = 8'h80; start = 1'b1;
      tick();                      // E0 (no product expected)
      start = 1'b0;
      tick(); tick(); tick();      // E1..E3
      check("abort_busy_pre", {15'd0, busy}, 16'd1);
      reset = 1'b1;
      tick();                      // E4
      reset = 1'b0;
      check("abort_busy", {15'd0, busy}, 16'd0);
      check("abort_out", out, 16'h0000);
      check("abort_done", {15'd0, done}, 16'd0);
      for (int i = 0; i < 10; i++) begin
         tick();
         check("abort_no_done", {15'd0, done}, 16'd0);
      end
      run_op(8'd2, 8'd3, 16'h0006);

      // Held start restarts from every DONE with the operands present then
      inA = 8'd7; inB = 8'd9; start = 1'b1;
      sb_q.push_back(16'd63);
      tick();
      wait_done(20, lat);
      check("held_latency", 16'(lat), 16'd8);
      inA = 8'd5; inB = 8'd6;
      sb_q.push_back(16'd30);
      tick();
      start = 1'b0;
      check("held_restart_busy", {15'd0, busy}, 16'd1);
      wait_done(20, lat);
      check("held_spacing", 16'(lat + 1), 16'd9);
      tick();

      check("scoreboard_empty", 16'(sb_q.size()), 16'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got no completion expected finish by 200000");
      $fatal(1, "timeout");
   end

endmodule
